// File: rtl/insmem_loader_if.sv
// Host-side byte stream and instruction-memory write bus for the program loader.
// The master side is the byte source (host link / bench), the slave side is the loader.
interface insmem_loader_if;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
    logic        done;
    logic        error;
    logic        core_hold;

    modport master (
        output start, in_data, in_valid,
        input  in_ready, wr_en, wr_addr, wr_data, busy, done, error, core_hold
    );

    modport slave (
        input  start, in_data, in_valid,
        output in_ready, wr_en, wr_addr, wr_data, busy, done, error, core_hold
    );
endinterface

// File: rtl/insmem_loader.sv
// Program loader: accepts a framed byte stream (16-bit little-endian length,
// payload, 8-bit additive checksum) and writes the payload byte by byte into
// instruction memory, keeping the core held until a frame loads cleanly.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | after reset, waiting for start
// LEN0   | waiting for length low byte
// LEN1   | waiting for length high byte, range-checked on arrival
// DATA   | payload bytes written to memory at the running address
// CSUM   | waiting for checksum byte (compared, never written)
// DONE   | frame loaded and checksum matched; core released
// ERR    | frame rejected (length too large or checksum mismatch)
module insmem_loader #(
    parameter int DEPTH_BYTES = 400
) (
    input logic             clk_i,
    input logic             rst_n_i,
    insmem_loader_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_CSUM, S_DONE, S_ERR
    } state_t;

    localparam logic [15:0] DEPTH_W = 16'(DEPTH_BYTES);

    state_t      state_q, state_d;
    logic [15:0] counter_q, counter_d;
    logic [15:0] length_q, length_d;
    logic [7:0]  csum_q, csum_d;
    logic        ready_q, done_q, error_q, hold_q;
    logic        xfer;
    logic [15:0] len_full;

    // A byte is consumed only when the loader advertised ready this cycle.
    assign xfer     = bus.in_valid && ready_q;
    assign len_full = {bus.in_data, length_q[7:0]};

    // Next-state and datapath update for the frame parser.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        length_d  = length_q;
        csum_d    = csum_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (bus.start) begin
                    state_d   = S_LEN0;
                    counter_d = '0;
                    length_d  = '0;
                    csum_d    = '0;
                end
            end
            S_LEN0: begin
                if (xfer) begin
                    length_d[7:0] = bus.in_data;
                    state_d       = S_LEN1;
                end
            end
            S_LEN1: begin
                if (xfer) begin
                    length_d[15:8] = bus.in_data;
                    if (len_full > DEPTH_W) begin
                        state_d = S_ERR;
                    end else if (len_full == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (xfer) begin
                    counter_d = counter_q + 16'd1;
                    csum_d    = csum_q + bus.in_data;
                    if (counter_d == length_q) begin
                        state_d = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (xfer) begin
                    state_d = (bus.in_data == csum_q) ? S_DONE : S_ERR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, datapath and registered status flags (decoded from the next state).
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            counter_q <= '0;
            length_q  <= '0;
            csum_q    <= '0;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            hold_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            length_q  <= length_d;
            csum_q    <= csum_d;
            ready_q   <= (state_d == S_LEN0) || (state_d == S_LEN1) ||
                         (state_d == S_DATA) || (state_d == S_CSUM);
            done_q    <= (state_d == S_DONE);
            error_q   <= (state_d == S_ERR);
            hold_q    <= (state_d != S_DONE);
        end
    end

    // Write port is combinational so the memory samples the byte on the transfer edge.
    assign bus.wr_en     = xfer && (state_q == S_DATA);
    assign bus.wr_addr   = {16'd0, counter_q};
    assign bus.wr_data   = bus.in_data;
    assign bus.in_ready  = ready_q;
    assign bus.busy      = ready_q;
    assign bus.done      = done_q;
    assign bus.error     = error_q;
    assign bus.core_hold = hold_q;

endmodule
